reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank.sv | 113 +++++++++++
 tb/tb_reg_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file (r0 hardwired to zero) with a streaming dump port.
// Define REG_BANK_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_reg_write,
    input  logic [ADDR_WIDTH-1:0] i_write_register,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [ADDR_WIDTH-1:0] i_read_reg1,
    input  logic [ADDR_WIDTH-1:0] i_read_reg2,
    output logic [DATA_WIDTH-1:0] o_read_data1,
    output logic [DATA_WIDTH-1:0] o_read_data2,
    input  logic                  i_dbg_start,
    input  logic                  i_dbg_ready,
    output logic                  o_dbg_valid,
    output logic [ADDR_WIDTH-1:0] o_dbg_index,
    output logic [DATA_WIDTH-1:0] o_dbg_data,
    output logic                  o_dbg_busy,
    output logic                  o_dbg_done,
    output logic [1:0]            o_dbg_state
);

    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  wr_en;

    assign wr_en = i_reg_write && (i_write_register != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[i_write_register] <= i_write_data;
        end
    end

    // Index 0 is forced to zero on read as well, so r0 never depends on array contents.
    always_comb begin
        o_read_data1 = (i_read_reg1 == '0) ? '0 : regs[i_read_reg1];
        o_read_data2 = (i_read_reg2 == '0) ? '0 : regs[i_read_reg2];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en && (i_write_register == i_read_reg1)) begin
            o_read_data1 = i_write_data;
        end
        if (wr_en && (i_write_register == i_read_reg2)) begin
            o_read_data2 = i_write_data;
        end
`endif
    end

    // Dump handshake: a beat transfers on a rising edge where o_dbg_valid && i_dbg_ready;
    // index and data hold while the consumer stalls. i_dbg_start is only sampled in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (i_dbg_start) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (i_dbg_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign o_dbg_valid = (state == ST_STREAM);
    assign o_dbg_busy  = (state == ST_STREAM);
    assign o_dbg_done  = (state == ST_DONE);
    assign o_dbg_index = idx;
    assign o_dbg_state = state;

    // Dump data reads the array directly; bypass is deliberately not applied here.
    always_comb begin
        o_dbg_data = '0;
        if (o_dbg_valid && (idx != '0)) begin
            o_dbg_data = regs[idx];
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized write/read traffic
// compared against an array model of the register file.
module tb_reg_bank;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;
    logic [AW-1:0] ra1 = '0;
    logic [AW-1:0] ra2 = '0;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          dbg_start = 1'b0;
    logic          dbg_ready = 1'b0;
    logic          dbg_valid;
    logic [AW-1:0] dbg_index;
    logic [DW-1:0] dbg_data;
    logic          dbg_busy;
    logic          dbg_done;
    logic [1:0]    dbg_state;

    logic [DW-1:0] model [NR];
    int vectors = 0;
    int miscompares = 0;

    reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .i_reg_write(we), .i_write_register(wa), .i_write_data(wd),
        .i_read_reg1(ra1), .i_read_reg2(ra2),
        .o_read_data1(rd1), .o_read_data2(rd2),
        .i_dbg_start(dbg_start), .i_dbg_ready(dbg_ready),
        .o_dbg_valid(dbg_valid), .o_dbg_index(dbg_index), .o_dbg_data(dbg_data),
        .o_dbg_busy(dbg_busy), .o_dbg_done(dbg_done), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference read: stored value, r0 is zero, and same-cycle forwarding when enabled.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == '0) return '0;
`ifdef REG_BANK_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return model[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset && we && wa != '0) model[wa] = wd;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    task automatic check_reads(input string tag);
        #1;
        check({tag, "_rd1"}, rd1, exp_rd(ra1));
        check({tag, "_rd2"}, rd2, exp_rd(ra2));
    endtask

    task automatic check_beat(input int b);
        check("beat_valid", {31'd0, dbg_valid}, 32'd1);
        check("beat_busy", {31'd0, dbg_busy}, 32'd1);
        check("beat_index", {27'd0, dbg_index}, b);
        check("beat_data", dbg_data, model[b]);
    endtask

    initial begin
        clear_model();
        // Reset state
        #2;
        check("rst_valid", {31'd0, dbg_valid}, 32'd0);
        check("rst_busy", {31'd0, dbg_busy}, 32'd0);
        check("rst_done", {31'd0, dbg_done}, 32'd0);
        check("rst_index", {27'd0, dbg_index}, 32'd0);
        check("rst_data", dbg_data, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        for (int r = 1; r < NR; r++) begin
            ra1 = AW'(r);
            ra2 = AW'(NR - r);
            check_reads("post_reset");
            check("post_reset_zero", rd1, 32'd0);
        end

        // r0 discards writes
        we = 1'b1; wa = '0; wd = 32'hFFFF_FFFF;
        tick();
        we = 1'b0; ra1 = '0; ra2 = '0;
        check_reads("r0_write");
        check("r0_zero", rd1, 32'd0);

        we = 1'b1; wa = 5'd5; wd = 32'h1234_5678;
        tick();
        we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
        #1;
        check("r5_rd1", rd1, 32'h1234_5678);
        check("r5_rd2", rd2, 32'h1234_5678);

        // Same-cycle write/read of r7
        we = 1'b1; wa = 5'd7; wd = 32'hCAFE_F00D; ra1 = 5'd7; ra2 = 5'd5;
        #1;
`ifdef REG_BANK_BYPASS_EN
        check("same_cycle_r7", rd1, 32'hCAFE_F00D);
`else
        check("same_cycle_r7", rd1, 32'd0);
`endif
        tick();
        we = 1'b0;
        #1;
        check("after_write_r7", rd1, 32'hCAFE_F00D);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = AW'($urandom_range(0, NR - 1));
            wd  = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR - 1));
            ra2 = AW'($urandom_range(0, NR - 1));
            check_reads("rand");
            tick();
        end
        we = 1'b0;

        // Preload rN = N*4, full dump with ready held high
        for (int r = 1; r < NR; r++) begin
            we = 1'b1; wa = AW'(r); wd = DW'(r * 4);
            tick();
        end
        we = 1'b0;
        dbg_start = 1'b1;
        tick();
        dbg_start = 1'b0; dbg_ready = 1'b1;
        for (int b = 0; b < NR; b++) begin
            #1;
            check_beat(b);
            check("beat_const", dbg_data, DW'(b * 4));
            tick();
        end
        #1;
        check("done_pulse", {31'd0, dbg_done}, 32'd1);
        check("done_valid", {31'd0, dbg_valid}, 32'd0);
        check("done_busy", {31'd0, dbg_busy}, 32'd0);
        tick();
        #1;
        check("done_single", {31'd0, dbg_done}, 32'd0);
        check("idle_valid", {31'd0, dbg_valid}, 32'd0);

        // Stall at index 10, ignored restart, concurrent write ahead of the stream
        dbg_start = 1'b1;
        tick();
        dbg_start = 1'b0;
        for (int b = 0; b < 10; b++) tick();
        dbg_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            dbg_start = (s == 1);
            we = (s == 0); wa = 5'd20; wd = $urandom;
            #1;
            check("stall_index", {27'd0, dbg_index}, 32'd10);
            check("stall_data", dbg_data, 32'd40);
            tick();
        end
        we = 1'b0; dbg_start = 1'b0; dbg_ready = 1'b1;
        for (int b = 10; b < NR; b++) begin
            #1;
            check_beat(b);
            tick();
        end
        #1;
        check("stall_done", {31'd0, dbg_done}, 32'd1);
        tick();
        #1;
        check("no_restart", {31'd0, dbg_valid}, 32'd0);

        // Reset asserted at index 20 aborts the dump
        dbg_start = 1'b1;
        tick();
        dbg_start = 1'b0;
        for (int b = 0; b < 20; b++) tick();
        #1;
        check("abort_at20", {27'd0, dbg_index}, 32'd20);
        reset = 1'b0;
        clear_model();
        #1;
        check("abort_valid", {31'd0, dbg_valid}, 32'd0);
        check("abort_busy", {31'd0, dbg_busy}, 32'd0);
        check("abort_index", {27'd0, dbg_index}, 32'd0);
        check("abort_data", dbg_data, 32'd0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            ra1 = AW'(c % NR);
            ra2 = AW'((c + 7) % NR);
            #1;
            check("abort_no_done", {31'd0, dbg_done}, 32'd0);
            check("abort_rd1", rd1, 32'd0);
            check("abort_rd2", rd2, 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
